// File: rtl/ehgu_fifo_rd_ctrl.sv
// rtl/ehgu_fifo_rd_ctrl.sv - ehgu FIFO read-side controller with credit-counted output buffer
// Optional accepted-word counter enabled by defining EHGU_FIFO_RD_CNT_EN.
module ehgu_fifo_rd_ctrl #(
    parameter int WIDTH     = 8,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 3
) (
    input  logic             clk1,
    input  logic             rstn,
    input  logic             en,
    input  logic             empty,
    output logic             renable,
    input  logic [WIDTH-1:0] rdata,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic             busy,
    output logic [15:0]      rd_count
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int SUM_W = 5;

    logic [RD_LAT-1:0] r_lat_pipe;
    logic [WIDTH-1:0]  r_buf [BUF_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [OCC_W-1:0]  r_occ;

    logic [SUM_W-1:0]  w_inflight;
    logic              w_credit_ok;
    logic              w_push;
    logic              w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + SUM_W'(r_lat_pipe[i]);
        end
    end

    // Reserve a buffer slot for every read in flight, so no m_ready path reaches renable.
    assign w_credit_ok = (SUM_W'(r_occ) + w_inflight) < SUM_W'(BUF_DEPTH);
    assign renable     = rstn & en & ~empty & w_credit_ok;

    assign w_push  = r_lat_pipe[RD_LAT-1];
    assign m_valid = (r_occ != '0);
    assign m_data  = r_buf[r_rd_ptr];
    assign w_pop   = m_valid & m_ready;
    assign busy    = (r_occ != '0) | (|r_lat_pipe);

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            r_lat_pipe <= '0;
        end else begin
            r_lat_pipe <= (r_lat_pipe << 1) | RD_LAT'(renable);
        end
    end

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_buf[r_wr_ptr] <= rdata;
            r_wr_ptr        <= next_ptr(r_wr_ptr);
        end
    end

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
        end
    end

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            r_occ <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

`ifdef EHGU_FIFO_RD_CNT_EN
    logic [15:0] r_rd_count;

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            r_rd_count <= '0;
        end else if (w_pop) begin
            r_rd_count <= r_rd_count + 16'd1;
        end
    end

    assign rd_count = r_rd_count;
`else
    assign rd_count = '0;
`endif

endmodule

// File: tb/tb_ehgu_fifo_rd_ctrl.sv
// tb/tb_ehgu_fifo_rd_ctrl.sv - scoreboard bench for ehgu_fifo_rd_ctrl
// Counter phase runs only when EHGU_FIFO_RD_CNT_EN is defined.
module tb_ehgu_fifo_rd_ctrl;

    localparam int W   = 8;
    localparam int LAT = 1;
    localparam int DEP = 3;

    logic          clk1 = 1'b0;
    logic          rstn = 1'b0;
    logic          en = 1'b0;
    logic          empty = 1'b1;
    logic          renable;
    logic [W-1:0]  rdata = '0;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_ready = 1'b0;
    logic          busy;
    logic [15:0]   rd_count;

    ehgu_fifo_rd_ctrl #(.WIDTH(W), .RD_LAT(LAT), .BUF_DEPTH(DEP)) dut (
        .clk1     (clk1),
        .rstn     (rstn),
        .en       (en),
        .empty    (empty),
        .renable  (renable),
        .rdata    (rdata),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .busy     (busy),
        .rd_count (rd_count)
    );

    always #5 clk1 = ~clk1;

    logic [W-1:0] src_q[$];
    logic [W-1:0] exp_q[$];
    int           t_q[$];
    int           cyc = 0;
    bit           ren_seen = 1'b0;
    logic [15:0]  exp_cnt = '0;
    int           checks = 0;
    int           passes = 0;

    always @(posedge clk1) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    endtask

    // Monitor: reference expectations from issue order and read latency.
    always @(negedge clk1) begin
        if (!rstn) begin
            chk("rst_renable", renable, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rd_count", rd_count, 0);
            chk("rst_m_data", m_data, 0);
            ren_seen = 1'b0;
        end else begin
            bit exp_ren, exp_v;
            exp_ren = en && !empty && (exp_q.size() < DEP);
            exp_v   = (exp_q.size() > 0) && (cyc >= t_q[0] + LAT);
            chk("renable", renable, exp_ren);
            chk("m_valid", m_valid, exp_v);
            chk("busy", busy, exp_q.size() != 0);
            chk("rd_count", rd_count, exp_cnt);
            ren_seen = renable;
            if (m_valid && exp_v) begin
                chk("m_data", m_data, exp_q[0]);
                if (m_ready) begin
                    void'(exp_q.pop_front());
                    void'(t_q.pop_front());
`ifdef EHGU_FIFO_RD_CNT_EN
                    exp_cnt = exp_cnt + 16'd1;
`endif
                end
            end
        end
    end

    // Memory model: a read issued at one edge presents its word for the next edge.
    task automatic step();
        @(posedge clk1);
        #1;
        if (ren_seen && rstn && src_q.size() > 0) begin
            rdata = src_q.pop_front();
            exp_q.push_back(rdata);
            t_q.push_back(cyc);
        end else begin
            rdata = W'($urandom);
        end
        empty = (src_q.size() == 0);
    endtask

    task automatic load(input int n, input bit rnd, input int base);
        for (int i = 0; i < n; i++) src_q.push_back(rnd ? W'($urandom) : W'(base + i));
        empty = (src_q.size() == 0);
    endtask

    task automatic drain(input int budget);
        int i;
        for (i = 0; i < budget && (src_q.size() != 0 || exp_q.size() != 0); i++) step();
        chk("drain_done", (src_q.size() == 0 && exp_q.size() == 0), 1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        exp_q.delete();
        t_q.delete();
        exp_cnt = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        en = 1'b1;
        m_ready = 1'b1;
        load(8, 0, 1);
        repeat (3) step();
        rstn = 1'b1;
        drain(100);
        repeat (3) step();

        m_ready = 1'b0;
        load(10, 0, 1);
        repeat (10) step();
        m_ready = 1'b1;
        drain(100);

        load(20, 0, 8'h20);
        for (int i = 0; i < 60 && exp_q.size() + src_q.size() != 0; i++) begin
            step();
            m_ready = i[0];
        end
        m_ready = 1'b1;
        drain(100);

        for (int i = 0; i < 400; i++) begin
            step();
            if ($urandom_range(0, 3) == 0) load($urandom_range(1, 5), 1, 0);
            if ($urandom_range(0, 15) == 0) empty = 1'b1;
            else empty = (src_q.size() == 0);
            m_ready = $urandom_range(0, 2) != 0;
            en      = $urandom_range(0, 7) != 0;
        end
        en = 1'b1;
        m_ready = 1'b1;
        drain(200);

        load(12, 0, 8'h40);
        m_ready = $urandom_range(0, 1);
        repeat (5) step();
        #1;
        do_reset();
        repeat (2) step();
        rstn = 1'b1;
        m_ready = 1'b1;
        drain(100);

`ifdef EHGU_FIFO_RD_CNT_EN
        step();
        #1;
        do_reset();
        step();
        rstn = 1'b1;
        load(65537, 1, 0);
        drain(70000);
        repeat (2) step();
        chk("rd_count_wrap", rd_count, 16'd1);
`endif

        repeat (3) step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
